// File: rtl/axis_verifier_pkg.sv
// Shared types and helpers for the AXI-Stream slave verifiers.
// Lane FSM states and the stall counter width function.
package axis_verifier_pkg;

  typedef enum logic [1:0] {
    VS_PASS,
    VS_DRAIN,
    VS_BLOCK
  } verif_state_t;

  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/axis_slave_verifier_lane.sv
// One verifier lane: stall timeout, error latch, isolation FSM
// and saturating dropped-beat counter.
module axis_slave_verifier_lane
  import axis_verifier_pkg::*;
#(
  parameter int AXIS_BUS_WIDTH        = 64,
  parameter int AXIS_DEST_WIDTH       = 4,
  parameter int INCLUDE_TIMEOUT_ERROR = 1,
  parameter int TIMEOUT_CYCLES        = 15,
  parameter int DROP_ON_TIMEOUT       = 1,
  parameter int DROP_COUNT_WIDTH      = 16
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [AXIS_BUS_WIDTH-1:0]     s_tdata,
  input  logic [AXIS_DEST_WIDTH-1:0]    s_tdest,
  input  logic [AXIS_BUS_WIDTH/8-1:0]   s_tkeep,
  input  logic                          s_tlast,
  input  logic                          s_tvalid,
  output logic                          s_tready,
  output logic [AXIS_BUS_WIDTH-1:0]     m_tdata,
  output logic [AXIS_DEST_WIDTH-1:0]    m_tdest,
  output logic [AXIS_BUS_WIDTH/8-1:0]   m_tkeep,
  output logic                          m_tlast,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic                          irq,
  input  logic                          clear,
  output logic [DROP_COUNT_WIDTH-1:0]   drop_count
);

  localparam int CW = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(TIMEOUT_CYCLES);
  localparam logic [DROP_COUNT_WIDTH-1:0] DMAX = '1;
  localparam bit EN_TO = INCLUDE_TIMEOUT_ERROR != 0;
  localparam bit EN_DROP = DROP_ON_TIMEOUT != 0;

  verif_state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic latch;
  logic rp, rp_nxt;
  logic pass, acc, timeout;

  assign pass    = state == VS_PASS;
  assign acc     = s_tvalid && s_tready;
  assign timeout = EN_TO && pass && cnt == CMAX;
  assign irq     = EN_TO && (timeout || latch);

  always_comb begin
    m_tdata  = s_tdata;
    m_tdest  = s_tdest;
    m_tkeep  = s_tkeep;
    m_tlast  = s_tlast;
    m_tvalid = pass ? s_tvalid : 1'b0;
    s_tready = pass ? m_tready : 1'b1;
  end

  always_comb begin
    state_nxt = state;
    rp_nxt    = rp;
    case (state)
      VS_PASS: begin
        if (timeout && !clear && EN_DROP)
          state_nxt = VS_DRAIN;
      end
      VS_DRAIN: begin
        if (clear)
          rp_nxt = 1'b1;
        if (acc && s_tlast)
          state_nxt = (rp || clear) ? VS_PASS : VS_BLOCK;
      end
      VS_BLOCK: begin
        if (clear && (!acc || s_tlast)) begin
          state_nxt = VS_PASS;
        end else if (acc && !s_tlast) begin
          state_nxt = VS_DRAIN;
          if (clear)
            rp_nxt = 1'b1;
        end
      end
      default: state_nxt = VS_PASS;
    endcase
    if (state_nxt == VS_PASS)
      rp_nxt = 1'b0;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state <= VS_PASS;
      rp    <= 1'b0;
    end else begin
      state <= state_nxt;
      rp    <= rp_nxt;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn || clear)
      cnt <= '0;
    else if (pass && s_tvalid && m_tready)
      cnt <= '0;
    else if (s_tvalid && !m_tready && !timeout && cnt != CMAX)
      cnt <= cnt + 1'b1;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn || clear)
      latch <= 1'b0;
    else if (timeout)
      latch <= 1'b1;
  end

  // Only beats swallowed while isolated count as drops.
  always_ff @(posedge aclk) begin
    if (!aresetn)
      drop_count <= '0;
    else if (!pass && acc && drop_count != DMAX)
      drop_count <= drop_count + 1'b1;
  end

endmodule

// File: rtl/axis_slave_verifier_mc.sv
// Multi-channel AXI-Stream slave verifier.
// Maps packed per-lane slices onto independent verifier lanes.
module axis_slave_verifier_mc
  import axis_verifier_pkg::*;
#(
  parameter int NUM_CHANNELS          = 2,
  parameter int AXIS_BUS_WIDTH        = 64,
  parameter int AXIS_DEST_WIDTH       = 4,
  parameter int INCLUDE_TIMEOUT_ERROR = 1,
  parameter int TIMEOUT_CYCLES        = 15,
  parameter int DROP_ON_TIMEOUT       = 1,
  parameter int DROP_COUNT_WIDTH      = 16
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic [NUM_CHANNELS*AXIS_BUS_WIDTH-1:0]     axis_s_tdata,
  input  logic [NUM_CHANNELS*AXIS_DEST_WIDTH-1:0]    axis_s_tdest,
  input  logic [NUM_CHANNELS*AXIS_BUS_WIDTH/8-1:0]   axis_s_tkeep,
  input  logic [NUM_CHANNELS-1:0]                    axis_s_tlast,
  input  logic [NUM_CHANNELS-1:0]                    axis_s_tvalid,
  output logic [NUM_CHANNELS-1:0]                    axis_s_tready,
  output logic [NUM_CHANNELS*AXIS_BUS_WIDTH-1:0]     axis_m_tdata,
  output logic [NUM_CHANNELS*AXIS_DEST_WIDTH-1:0]    axis_m_tdest,
  output logic [NUM_CHANNELS*AXIS_BUS_WIDTH/8-1:0]   axis_m_tkeep,
  output logic [NUM_CHANNELS-1:0]                    axis_m_tlast,
  output logic [NUM_CHANNELS-1:0]                    axis_m_tvalid,
  input  logic [NUM_CHANNELS-1:0]                    axis_m_tready,
  output logic [NUM_CHANNELS-1:0]                    timeout_error_irq,
  input  logic [NUM_CHANNELS-1:0]                    timeout_error_clear,
  output logic [NUM_CHANNELS*DROP_COUNT_WIDTH-1:0]   drop_count
);

  localparam int W = AXIS_BUS_WIDTH;
  localparam int D = AXIS_DEST_WIDTH;
  localparam int K = AXIS_BUS_WIDTH / 8;
  localparam int C = DROP_COUNT_WIDTH;

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_lane
    axis_slave_verifier_lane #(
      .AXIS_BUS_WIDTH        (AXIS_BUS_WIDTH),
      .AXIS_DEST_WIDTH       (AXIS_DEST_WIDTH),
      .INCLUDE_TIMEOUT_ERROR (INCLUDE_TIMEOUT_ERROR),
      .TIMEOUT_CYCLES        (TIMEOUT_CYCLES),
      .DROP_ON_TIMEOUT       (DROP_ON_TIMEOUT),
      .DROP_COUNT_WIDTH      (DROP_COUNT_WIDTH)
    ) u_lane (
      .aclk       (aclk),
      .aresetn    (aresetn),
      .s_tdata    (axis_s_tdata[g*W +: W]),
      .s_tdest    (axis_s_tdest[g*D +: D]),
      .s_tkeep    (axis_s_tkeep[g*K +: K]),
      .s_tlast    (axis_s_tlast[g]),
      .s_tvalid   (axis_s_tvalid[g]),
      .s_tready   (axis_s_tready[g]),
      .m_tdata    (axis_m_tdata[g*W +: W]),
      .m_tdest    (axis_m_tdest[g*D +: D]),
      .m_tkeep    (axis_m_tkeep[g*K +: K]),
      .m_tlast    (axis_m_tlast[g]),
      .m_tvalid   (axis_m_tvalid[g]),
      .m_tready   (axis_m_tready[g]),
      .irq        (timeout_error_irq[g]),
      .clear      (timeout_error_clear[g]),
      .drop_count (drop_count[g*C +: C])
    );
  end

endmodule
